hilo_ctrl: RTL and testbench
============================

HILO_CTRL -- requirements
Module: hilo_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYC, default 63; maximum number of WAIT-state cycles before the multiply is abandoned.
REQ-002 clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 mult_e  in  1  MULT/MULTU in EX.
REQ-005 signed_e  in  1  1 = MULT (signed), 0 = MULTU.
REQ-006 src_a, src_b  in  32 each  EX operands.
REQ-007 mthi_e, mtlo_e, mfhi_e, mflo_e  in  1 each  HI/LO move instructions in EX.
REQ-008 flush_e  in  1  squash of the current EX instruction.
REQ-009 mul_en  out  1  level enable to the shift-add multiplier.
REQ-010 mul_a, mul_b  out  32 each  unsigned operands to the multiplier.
REQ-011 mul_done, mul_hi, mul_lo  in  1/32/32  multiplier completion flag and raw unsigned product.
REQ-012 stall  out  1  holds IF/ID/EX.
REQ-013 hilo_rd  out  32  MFHI/MFLO read data.
REQ-014 hi_q, lo_q  out  32 each  architectural HI and LO.
REQ-015 busy, err  out  1 each  multiply in flight; sticky timeout flag.

Function
REQ-016 FSM states SHALL be IDLE, LAUNCH, WAIT and FIXUP.
REQ-017 IDLE: mult_e & !flush_e -> capture operands and sign, go to LAUNCH; otherwise stay in IDLE.
REQ-018 LAUNCH: assert mul_en, clear the wait counter, go to WAIT.
REQ-019 WAIT: hold mul_en high; on mul_done go to FIXUP; when the counter reaches TIMEOUT_CYC, set err, drop mul_en and go to IDLE with HI/LO unchanged.
REQ-020 FIXUP: negate the 64-bit product when the sign flag is set, write {hi_q, lo_q}, drop mul_en, go to IDLE.
REQ-021 Latency from mult_e acceptance to HI/LO update SHALL be multiplier latency + 3 cycles.
REQ-022 mul_a/mul_b SHALL hold the magnitudes of the operands when signed, the raw operands when unsigned, and be stable from LAUNCH to FIXUP.
REQ-023 Sign flag SHALL equal signed_e & (src_a[31] ^ src_b[31]).
REQ-024 Magnitude of 0x80000000 SHALL be 0x80000000, treated as unsigned.
REQ-025 busy = (state != IDLE).
REQ-026 stall = busy & (mult_e | mfhi_e | mflo_e | mthi_e | mtlo_e); stall SHALL be 0 in IDLE.
REQ-027 In IDLE, mthi_e/mtlo_e without flush_e SHALL write src_a to HI/LO at the clock edge.
REQ-028 EX priority SHALL be mult_e > mthi_e > mtlo_e.
REQ-029 hilo_rd SHALL be combinational: hi_q when mfhi_e, lo_q when mflo_e, otherwise 0.
REQ-030 Same-cycle write and read SHALL return the old value.
REQ-031 flush_e SHALL only block acceptance in IDLE; an accepted multiply always completes or times out.
REQ-032 err SHALL be cleared only by reset.

Reset
REQ-033 Asserting rst SHALL force state IDLE and hi_q, lo_q, mul_a, mul_b, counter, mul_en, err and sign flag to 0, in any state, including mid-WAIT.

Configuration
REQ-034 Macro HILO_SIGNED_EN defined: signed handling per REQ-022 to REQ-024, with FIXUP negation.
REQ-035 HILO_SIGNED_EN undefined: signed_e is ignored, operands pass raw, the sign flag is tied to 0, and FIXUP still takes 1 cycle so latency is unchanged.

Structure
REQ-036 Package hilo_pkg SHALL hold the FSM state enum and the default TIMEOUT_CYC constant.
REQ-037 Sub-module hilo_neg64 SHALL perform the conditional 64-bit two's-complement negation used in FIXUP.

Verification
REQ-038 MULTU 7 x 6 -> hi_q = 0x0, lo_q = 0x2A after done + 3 cycles; busy is 0 afterwards.
REQ-039 MULT -3 x 5 (HILO_SIGNED_EN) -> hi_q = 0xFFFFFFFF, lo_q = 0xFFFFFFF1; MULT 0x80000000 x 2 -> hi_q = 0xFFFFFFFF, lo_q = 0x0.
REQ-040 mfhi_e asserted during WAIT -> stall = 1 until IDLE, then hilo_rd equals the new hi_q.
REQ-041 mthi_e with src_a = 0x1234, then mfhi_e -> hilo_rd = 0x1234; mult_e + flush_e in IDLE -> no LAUNCH.
REQ-042 rst asserted mid-WAIT -> hi_q = lo_q = 0, IDLE, mul_en = 0; mul_done held low for TIMEOUT_CYC cycles -> err = 1 and HI/LO unchanged.

Source files
------------

// File: rtl/hilo_pkg.sv
// Shared types and constants for the HI/LO multiply controller.
package hilo_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        FIXUP  = 2'd3
    } hilo_state_t;

    localparam int TIMEOUT_CYC_DEF = 63;

    // |v| for a 32-bit two's-complement value; 0x80000000 maps onto itself,
    // which is the correct magnitude once read as unsigned.
    function automatic logic [31:0] mag32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/hilo_if.sv
// Handshake between the HI/LO controller (master) and the shift-add multiplier (slave).
interface hilo_if;
    logic        mul_en;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic        mul_done;
    logic [31:0] mul_hi;
    logic [31:0] mul_lo;

    modport master (output mul_en, mul_a, mul_b, input mul_done, mul_hi, mul_lo);
    modport slave  (input mul_en, mul_a, mul_b, output mul_done, mul_hi, mul_lo);
endinterface

// File: rtl/hilo_neg64.sv
// Conditional 64-bit two's-complement negation applied to the raw product.
module hilo_neg64 (
    input  logic        neg,
    input  logic [63:0] din,
    output logic [63:0] dout
);
    assign dout = neg ? (~din + 64'd1) : din;
endmodule

// File: rtl/hilo_ctrl.sv
// HI/LO register file plus MULT/MULTU sequencer around an external multiplier.
// Optional macro HILO_SIGNED_EN enables signed MULT (magnitude operands, negated product).
module hilo_ctrl
    import hilo_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mult_e,
    input  logic        signed_e,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        mthi_e,
    input  logic        mtlo_e,
    input  logic        mfhi_e,
    input  logic        mflo_e,
    input  logic        flush_e,
    hilo_if.master      mul,
    output logic        stall,
    output logic [31:0] hilo_rd,
    output logic [31:0] hi_q,
    output logic [31:0] lo_q,
    output logic        busy,
    output logic        err
);

    localparam int CW = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYC);

    hilo_state_t state_reg, state_next;
    logic [CW-1:0] cnt_reg;
    logic [31:0]   hi_reg, lo_reg, a_reg, b_reg;
    logic [63:0]   prod_reg, prod_fixed;
    logic          mul_en_reg, err_reg, sign;
    logic [31:0]   op_a, op_b;
    logic          accept;

    assign accept = mult_e && !flush_e;

`ifdef HILO_SIGNED_EN
    logic sign_reg;
    assign op_a = signed_e ? mag32(src_a) : src_a;
    assign op_b = signed_e ? mag32(src_b) : src_b;
    assign sign = sign_reg;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            sign_reg <= 1'b0;
        else if (state_reg == IDLE && accept)
            sign_reg <= signed_e & (src_a[31] ^ src_b[31]);
    end
`else
    logic unused_signed;
    assign unused_signed = signed_e;
    assign op_a = src_a;
    assign op_b = src_b;
    assign sign = 1'b0;
`endif

    hilo_neg64 u_neg (
        .neg  (sign),
        .din  (prod_reg),
        .dout (prod_fixed)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = LAUNCH;
            LAUNCH:  state_next = WAIT;
            WAIT: begin
                if (mul.mul_done)
                    state_next = FIXUP;
                else if (cnt_reg == CNT_MAX)
                    state_next = IDLE;
            end
            FIXUP:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state_reg != IDLE);
        stall   = busy & (mult_e | mfhi_e | mflo_e | mthi_e | mtlo_e);
        hilo_rd = 32'd0;
        if (mfhi_e)
            hilo_rd = hi_reg;
        else if (mflo_e)
            hilo_rd = lo_reg;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_reg     <= 32'd0;
            lo_reg     <= 32'd0;
            a_reg      <= 32'd0;
            b_reg      <= 32'd0;
            prod_reg   <= 64'd0;
            cnt_reg    <= '0;
            mul_en_reg <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            // Enable is high for exactly the cycles spent in WAIT.
            mul_en_reg <= (state_next == WAIT);
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        a_reg <= op_a;
                        b_reg <= op_b;
                    end else if (mthi_e && !flush_e) begin
                        hi_reg <= src_a;
                    end else if (mtlo_e && !flush_e) begin
                        lo_reg <= src_a;
                    end
                end
                LAUNCH: cnt_reg <= '0;
                WAIT: begin
                    if (mul.mul_done)
                        prod_reg <= {mul.mul_hi, mul.mul_lo};
                    else if (cnt_reg == CNT_MAX)
                        err_reg <= 1'b1;
                    else
                        cnt_reg <= cnt_reg + 1'b1;
                end
                FIXUP: {hi_reg, lo_reg} <= prod_fixed;
                default: ;
            endcase
        end
    end

    assign mul.mul_en = mul_en_reg;
    assign mul.mul_a  = a_reg;
    assign mul.mul_b  = b_reg;
    assign hi_q       = hi_reg;
    assign lo_q       = lo_reg;
    assign err        = err_reg;

endmodule

// File: tb/tb_hilo_ctrl.sv
// Directed bench for hilo_ctrl with a fixed-latency behavioural multiplier.
module tb_hilo_ctrl;
    import hilo_pkg::*;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        mult_e, signed_e, mthi_e, mtlo_e, mfhi_e, mflo_e, flush_e;
    logic [31:0] src_a, src_b;
    logic        stall, busy, err;
    logic [31:0] hilo_rd, hi_q, lo_q;
    logic        hang;
    int          m_cnt;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    hilo_if bus ();

    hilo_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .mult_e   (mult_e),
        .signed_e (signed_e),
        .src_a    (src_a),
        .src_b    (src_b),
        .mthi_e   (mthi_e),
        .mtlo_e   (mtlo_e),
        .mfhi_e   (mfhi_e),
        .mflo_e   (mflo_e),
        .flush_e  (flush_e),
        .mul      (bus),
        .stall    (stall),
        .hilo_rd  (hilo_rd),
        .hi_q     (hi_q),
        .lo_q     (lo_q),
        .busy     (busy),
        .err      (err)
    );

    // Multiplier: registered done LAT cycles after enable rises; hang suppresses done.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_cnt        <= 0;
            bus.mul_done <= 1'b0;
            bus.mul_hi   <= 32'd0;
            bus.mul_lo   <= 32'd0;
        end else if (!bus.mul_en) begin
            m_cnt        <= 0;
            bus.mul_done <= 1'b0;
        end else if (!hang) begin
            if (m_cnt == LAT - 1) begin
                bus.mul_done <= 1'b1;
                {bus.mul_hi, bus.mul_lo} <= {32'd0, bus.mul_a} * {32'd0, bus.mul_b};
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ex();
        mult_e = 0; signed_e = 0; mthi_e = 0; mtlo_e = 0;
        mfhi_e = 0; mflo_e = 0; flush_e = 0; src_a = 0; src_b = 0;
    endtask

    task automatic run_mult(input string name, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] ea, input logic [31:0] eb,
                            input logic [31:0] ehi, input logic [31:0] elo);
        logic [31:0] old_hi, old_lo;
        old_hi = hi_q;
        old_lo = lo_q;
        mult_e = 1; signed_e = sgn; src_a = a; src_b = b;
        step();
        clear_ex();
        step();
        step();
        check_val({name, "_mul_en"}, bus.mul_en, 1);
        check_val({name, "_mul_a"}, bus.mul_a, ea);
        check_val({name, "_mul_b"}, bus.mul_b, eb);
        repeat (LAT) step();
        check_val({name, "_hi_before"}, hi_q, old_hi);
        check_val({name, "_lo_before"}, lo_q, old_lo);
        check_val({name, "_busy_fixup"}, busy, 1);
        step();
        check_val({name, "_hi"}, hi_q, ehi);
        check_val({name, "_lo"}, lo_q, elo);
        check_val({name, "_busy_after"}, busy, 0);
        $display("TXN %s a=%h b=%h signed=%0b -> hi=%h lo=%h", name, a, b, sgn, hi_q, lo_q);
    endtask

    initial begin
        int n;
        rst = 0;
        hang = 0;
        clear_ex();
        repeat (3) step();
        check_val("rst_hi", hi_q, 0);
        check_val("rst_lo", lo_q, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_err", err, 0);
        check_val("rst_mul_en", bus.mul_en, 0);
        check_val("rst_stall", stall, 0);
        rst = 1;
        step();

        run_mult("multu_7x6", 0, 32'd7, 32'd6, 32'd7, 32'd6, 32'h0, 32'h2A);
        run_mult("multu_max", 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                 32'hFFFFFFFE, 32'h00000001);
`ifdef HILO_SIGNED_EN
        run_mult("mult_m3x5", 1, 32'hFFFFFFFD, 32'd5, 32'd3, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1);
        run_mult("mult_min_x2", 1, 32'h80000000, 32'd2, 32'h80000000, 32'd2, 32'hFFFFFFFF, 32'h0);
        run_mult("mult_m7xm9", 1, 32'hFFFFFFF9, 32'hFFFFFFF7, 32'd7, 32'd9, 32'h0, 32'h3F);
`else
        run_mult("mult_m3x5", 1, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFD, 32'd5, 32'h4, 32'hFFFFFFF1);
        run_mult("mult_min_x2", 1, 32'h80000000, 32'd2, 32'h80000000, 32'd2, 32'h1, 32'h0);
        run_mult("mult_m7xm9", 1, 32'hFFFFFFF9, 32'hFFFFFFF7, 32'hFFFFFFF9, 32'hFFFFFFF7,
                 32'hFFFFFFF0, 32'h3F);
`endif

        // HI/LO moves, read priority and read-before-write.
        mthi_e = 1; src_a = 32'h1234; step(); clear_ex();
        mtlo_e = 1; src_a = 32'h5678; step(); clear_ex();
        mfhi_e = 1; #1;
        check_val("mfhi_1234", hilo_rd, 32'h1234);
        check_val("stall_idle", stall, 0);
        mfhi_e = 0; mflo_e = 1; #1;
        check_val("mflo_5678", hilo_rd, 32'h5678);
        mfhi_e = 1; #1;
        check_val("mfhi_over_mflo", hilo_rd, 32'h1234);
        clear_ex(); #1;
        check_val("rd_none", hilo_rd, 0);
        mthi_e = 1; mfhi_e = 1; src_a = 32'hAAAA; #1;
        check_val("rd_old_same_cycle", hilo_rd, 32'h1234);
        step(); clear_ex();
        check_val("mthi_new", hi_q, 32'hAAAA);
        mthi_e = 1; mtlo_e = 1; src_a = 32'h7777; step(); clear_ex();
        check_val("mthi_prio_hi", hi_q, 32'h7777);
        check_val("mthi_prio_lo", lo_q, 32'h5678);
        mult_e = 1; mthi_e = 1; src_a = 32'h3; src_b = 32'h4; flush_e = 1; step(); clear_ex();
        check_val("flush_no_launch", busy, 0);
        check_val("flush_no_mthi", hi_q, 32'h7777);
        $display("TXN moves hi=%h lo=%h", hi_q, lo_q);

        // MFHI during a multiply stalls until the new HI is visible.
        mult_e = 1; src_a = 32'h10000; src_b = 32'h10000; step(); clear_ex();
        mfhi_e = 1;
        step(); step();
        check_val("wait_stall", stall, 1);
        n = 0;
        while (busy && n < 20) begin
            step();
            n++;
        end
        check_val("wait_to_idle_cycles", n, 4);
        check_val("wait_stall_released", stall, 0);
        check_val("wait_mfhi_new", hilo_rd, 32'h1);
        clear_ex();
        $display("TXN mfhi_stall cycles=%0d rd=%h", n, hilo_rd);

        // Reset in the middle of WAIT.
        mult_e = 1; src_a = 32'd9; src_b = 32'd9; step(); clear_ex();
        step(); step();
        rst = 0; #1;
        check_val("midrst_hi", hi_q, 0);
        check_val("midrst_lo", lo_q, 0);
        check_val("midrst_busy", busy, 0);
        check_val("midrst_mul_en", bus.mul_en, 0);
        check_val("midrst_mul_a", bus.mul_a, 0);
        step(); rst = 1; step();
        $display("TXN mid_wait_reset");

        // Timeout: done never arrives.
        mthi_e = 1; src_a = 32'hCAFE; step(); clear_ex();
        mtlo_e = 1; src_a = 32'hBEEF; step(); clear_ex();
        hang = 1;
        mult_e = 1; src_a = 32'd5; src_b = 32'd5; step(); clear_ex();
        repeat (TIMEOUT_CYC_DEF + 1) step();
        check_val("to_busy_last", busy, 1);
        check_val("to_err_early", err, 0);
        step();
        check_val("to_busy_done", busy, 0);
        check_val("to_err", err, 1);
        check_val("to_hi", hi_q, 32'hCAFE);
        check_val("to_lo", lo_q, 32'hBEEF);
        check_val("to_mul_en", bus.mul_en, 0);
        hang = 0;
        $display("TXN timeout err=%0b", err);
        run_mult("after_to", 0, 32'd7, 32'd6, 32'd7, 32'd6, 32'h0, 32'h2A);
        check_val("err_sticky", err, 1);
        rst = 0; #1;
        check_val("err_rst_clear", err, 0);
        step(); rst = 1; step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
